// File: rtl/frame_serializer_pkg.sv
// rtl/frame_serializer_pkg.sv - shared types and helpers for frame_serializer
package serializer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } ser_state_t;

  localparam logic IDLE_LEVEL = 1'b1;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_serializer_if.sv
// rtl/frame_serializer_if.sv - word input handshake for frame_serializer
interface frame_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  in_valid;
  logic                  in_ready;

  modport master (output data_in, output in_valid, input in_ready);
  modport slave  (input data_in, input in_valid, output in_ready);
endinterface

// File: rtl/frame_serializer_bit_timer.sv
// rtl/frame_serializer_bit_timer.sv - reloadable down-counter marking the last cycle of each line bit
module bit_timer
  import serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic reload,
  output logic bit_end
);
  localparam int TW = (clog2(CLKS_PER_BIT) > 1) ? clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] RELOAD_VAL = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] count_q, count_d;

  // Parks at zero so bit_end stays high until the FSM reloads.
  always_comb begin
    count_d = count_q;
    if (reload) begin
      count_d = RELOAD_VAL;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bit_end = (count_q == '0);
endmodule

// File: rtl/frame_serializer.sv
// rtl/frame_serializer.sv - UART-style framed serializer with one-deep holding register
// Build option SERIALIZER_PARITY_EN inserts an even-parity bit after the data bits.
module frame_serializer
  import serializer_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int MSB_FIRST    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clock,
  input  logic              reset,
  frame_serializer_if.slave in_if,
  output logic              data_out,
  output logic              busy,
  output logic              done
);
  localparam int CW = clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  ser_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
`ifdef SERIALIZER_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  logic                  accept, bit_end, reload, load_en, direct, data_bit;
  logic [DATA_WIDTH-1:0] load_word, shift_next;

  assign in_if.in_ready = !hold_full_q;
  assign accept         = in_if.in_valid && !hold_full_q;
  assign busy           = (state_q != IDLE);
  assign data_bit       = (MSB_FIRST != 0) ? shift_q[DATA_WIDTH-1] : shift_q[0];
  assign shift_next     = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .reload (reload),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    reload      = 1'b0;
    load_en     = 1'b0;
    load_word   = in_if.data_in;
    direct      = 1'b0;
    data_out    = IDLE_LEVEL;
    done        = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    parity_d    = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        direct = 1'b1;
        if (accept) begin
          load_en = 1'b1;
          reload  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        data_out = 1'b0;
        if (bit_end) begin
          reload    = 1'b1;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        data_out = data_bit;
        if (bit_end) begin
          reload = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            stop_cnt_d = 1'b0;
`ifdef SERIALIZER_PARITY_EN
            state_d    = PARITY;
`else
            state_d    = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_next;
          end
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        data_out = parity_q;
        if (bit_end) begin
          reload  = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (stop_cnt_q == LAST_STOP) begin
            // End of frame: a waiting word starts the next frame with no idle gap.
            done   = 1'b1;
            direct = 1'b1;
            if (hold_full_q) begin
              load_en     = 1'b1;
              load_word   = hold_q;
              hold_full_d = 1'b0;
              reload      = 1'b1;
              state_d     = START;
            end else if (accept) begin
              load_en = 1'b1;
              reload  = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = 1'b1;
            reload     = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_en) begin
      shift_d = load_word;
`ifdef SERIALIZER_PARITY_EN
      parity_d = ^load_word;
`endif
    end
    if (accept && !direct) begin
      hold_d      = in_if.data_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end
endmodule
